// File: rtl/mem_stage.sv
// Memory-access stage: registers the EX bus, aligns/extends load data,
// and drives the write-back and forwarding buses.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 76,
    parameter int MEM_TO_WB_WD = 70,
    parameter int MEM_TO_RF_WD = 38,
    parameter int LOAD_BUS_WD  = 5,
    parameter int STALL_BUS_WD = 6
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [STALL_BUS_WD-1:0] stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [LOAD_BUS_WD-1:0]  ex_load_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
    output logic                    mem_is_load
);

    typedef enum logic {LIVE, HELD} state_t;

    logic [EX_TO_MEM_WD-1:0] bus_r;
    logic [LOAD_BUS_WD-1:0]  load_r;
    logic [31:0]             rdata_hold;
    state_t                  state;
    state_t                  state_nxt;

    logic        stall_mem;
    logic        stall_wb;
    logic        bubble;
    logic        capture;
    logic        advance;
    logic        go_held;

    logic [31:0] pc;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [31:0] word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    // Store controls finish in EX; other stall bits belong to other stages.
    logic unused_bits;
    assign unused_bits = ^{bus_r[43:39], stall[2:0], stall[5]};

    assign stall_mem = stall[3];
    assign stall_wb  = stall[4];
    assign bubble    = stall_mem & ~stall_wb;
    assign capture   = ~stall_mem;
    assign advance   = capture | bubble;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_r  <= '0;
            load_r <= '0;
        end else if (bubble) begin
            bus_r  <= '0;
            load_r <= '0;
        end else if (capture) begin
            bus_r  <= ex_to_mem_bus;
            load_r <= ex_load_bus;
        end
    end

    assign pc         = bus_r[75:44];
    assign sel_rf_res = bus_r[38];
    assign rf_we      = bus_r[37];
    assign rf_waddr   = bus_r[36:32];
    assign ex_result  = bus_r[31:0];
    assign mem_is_load = |load_r;

    assign go_held = stall_wb & mem_is_load;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= LIVE;
            rdata_hold <= '0;
        end else begin
            state <= state_nxt;
            if (state == LIVE && go_held)
                rdata_hold <= data_sram_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LIVE: if (go_held) state_nxt = HELD;
            HELD: if (advance) state_nxt = LIVE;
            default: state_nxt = LIVE;
        endcase
    end

    always_comb begin
        word = (state == HELD) ? rdata_hold : data_sram_rdata;
    end

    always_comb begin
        byte_sel = '0;
        unique case (ex_result[1:0])
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = '0;
        endcase
    end

    assign half_sel = ex_result[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = '0;
        unique case (1'b1)
            load_r[4]: load_data = {{24{byte_sel[7]}}, byte_sel};
            load_r[3]: load_data = {24'd0, byte_sel};
            load_r[2]: load_data = {{16{half_sel[15]}}, half_sel};
            load_r[1]: load_data = {16'd0, half_sel};
            load_r[0]: load_data = word;
            default:   load_data = '0;
        endcase
    end

    assign rf_wdata      = sel_rf_res ? load_data : ex_result;
    assign mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata};
    assign mem_to_wb_bus = {pc, mem_to_rf_bus};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected WB words are queued at
// drive time and compared one cycle later.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic [5:0]  stall;
    logic [75:0] ex_to_mem_bus;
    logic [4:0]  ex_load_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_rf_bus;
    logic        mem_is_load;

    int n_checks;
    int n_fail;

    logic [70:0] exp_q[$];

    localparam logic [4:0] LD_LB  = 5'b10000;
    localparam logic [4:0] LD_LBU = 5'b01000;
    localparam logic [4:0] LD_LH  = 5'b00100;
    localparam logic [4:0] LD_LHU = 5'b00010;
    localparam logic [4:0] LD_LW  = 5'b00001;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_load_bus     (ex_load_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_rf_bus   (mem_to_rf_bus),
        .mem_is_load     (mem_is_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] act,
                         input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic sel,
                         input logic we, input logic [4:0] wa,
                         input logic [31:0] res, input logic [4:0] ld,
                         input logic [31:0] rd);
        ex_to_mem_bus   = {pc, 1'b0, 4'b0, sel, we, wa, res};
        ex_load_bus     = ld;
        data_sram_rdata = rd;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd,
                            input logic ld);
        exp_q.push_back({ld, pc, we, wa, wd});
    endtask

    task automatic compare_out(input string tag);
        logic [70:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", tag,
                     mem_to_wb_bus);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_wb"}, mem_to_wb_bus, e[69:0]);
            check({tag, "_rf"}, {32'd0, mem_to_rf_bus}, {32'd0, e[37:0]});
            check({tag, "_ld"}, {69'd0, mem_is_load}, {69'd0, e[70]});
        end
    endtask

    task automatic sample(input string tag);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        stall    = '0;
        drive(32'h1111_2222, 1'b0, 1'b1, 5'd9, 32'hCAFE_0001, 5'd0,
              32'h0);
        #2;
        check("rst_wb", mem_to_wb_bus, '0);
        check("rst_rf", {32'd0, mem_to_rf_bus}, '0);
        check("rst_ld", {69'd0, mem_is_load}, '0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // nonzero capture, then asynchronous reset mid-cycle
        drive(32'h1111_2222, 1'b0, 1'b1, 5'd9, 32'hCAFE_0001, 5'd0,
              32'h0);
        push_exp(32'h1111_2222, 1'b1, 5'd9, 32'hCAFE_0001, 1'b0);
        sample("pre_rst");
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_wb", mem_to_wb_bus, '0);
        check("async_rst_rf", {32'd0, mem_to_rf_bus}, '0);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        drive(32'h0000_0100, 1'b1, 1'b1, 5'd7, 32'h0000_1003, LD_LB,
              32'h80FF_1234);
        push_exp(32'h0000_0100, 1'b1, 5'd7, 32'hFFFF_FF80, 1'b1);
        sample("lb");
        drive(32'h0000_0104, 1'b1, 1'b1, 5'd8, 32'h0000_1003, LD_LBU,
              32'h80FF_1234);
        push_exp(32'h0000_0104, 1'b1, 5'd8, 32'h0000_0080, 1'b1);
        sample("lbu");
        drive(32'h0000_0108, 1'b1, 1'b1, 5'd10, 32'h0000_2002, LD_LH,
              32'h8001_7FFF);
        push_exp(32'h0000_0108, 1'b1, 5'd10, 32'hFFFF_8001, 1'b1);
        sample("lh");
        drive(32'h0000_010C, 1'b1, 1'b1, 5'd11, 32'h0000_2000, LD_LHU,
              32'h8001_7FFF);
        push_exp(32'h0000_010C, 1'b1, 5'd11, 32'h0000_7FFF, 1'b1);
        sample("lhu0");
        drive(32'h0000_0110, 1'b1, 1'b0, 5'd12, 32'h0000_2001, LD_LHU,
              32'h8001_7FFF);
        push_exp(32'h0000_0110, 1'b0, 5'd12, 32'h0000_7FFF, 1'b1);
        sample("lhu1");

        // lw, then WB+MEM stall while SRAM output moves on
        drive(32'h0000_0200, 1'b1, 1'b1, 5'd3, 32'h0000_3000, LD_LW,
              32'hDEAD_BEEF);
        push_exp(32'h0000_0200, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1);
        sample("lw");
        stall = 6'b011000;
        push_exp(32'h0000_0200, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1);
        sample("stall0");
        data_sram_rdata = 32'h1234_5678;
        ex_to_mem_bus   = '1;
        ex_load_bus     = LD_LB;
        push_exp(32'h0000_0200, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1);
        #1;
        compare_out("stall_held");
        push_exp(32'h0000_0200, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1);
        sample("stall1");
        push_exp(32'h0000_0200, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1);
        sample("stall2");
        stall = '0;
        drive(32'h0000_0204, 1'b1, 1'b1, 5'd4, 32'h0000_3004, LD_LW,
              32'h1234_5678);
        push_exp(32'h0000_0204, 1'b1, 5'd4, 32'h1234_5678, 1'b1);
        sample("post_stall");

        stall = 6'b001000;
        drive(32'h0000_0300, 1'b1, 1'b1, 5'd6, 32'h0000_4000, LD_LW,
              32'h5555_AAAA);
        push_exp(32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        sample("bubble");
        stall = '0;

        drive(32'hBFC0_0010, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 5'd0,
              32'hFFFF_FFFF);
        push_exp(32'hBFC0_0010, 1'b1, 5'd5, 32'h0000_1234, 1'b0);
        sample("alu");

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0",
                     exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation limit reached");
        $fatal(1, "timeout");
    end

endmodule
